vga_pingpong_fb: RTL and testbench

- Parametrised double-buffered (ping-pong) framebuffer between the game renderer (write side) and the VGA timing generator (read side).
- One bank is written by the renderer while the other is scanned out.
- Adds over the previous fixed-size block:
  - configurable geometry, scale and rotation;
  - a requested, frame-aligned swap handshake (or free-running auto swap);
  - a fixed, pipelined read latency with a valid flag;
  - a background fill value outside the stored window.

---
 rtl/vga_pingpong_fb.sv | 129 ++++++++++++
 tb/tb_vga_pingpong_fb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pingpong_fb.sv
// Double-buffered framebuffer between the renderer (write side) and the VGA scan-out (read side).
// Frame-aligned bank swap, rotated/scaled coordinate map, fixed 2-cycle read latency with valid.
module vga_pingpong_fb #(
   parameter int DATA_W    = 8,
   parameter int FB_COLS   = 240,
   parameter int FB_ROWS   = 264,
   parameter int SCALE     = 2,
   parameter int ROTATE    = 1,
   parameter int Y_OFFSET  = 24,
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int H_TOTAL   = 800,
   parameter int V_TOTAL   = 525,
   parameter int AUTO_SWAP = 0,
   parameter int BG_DATA   = 0,
   parameter int DEPTH     = FB_COLS * FB_ROWS,
   parameter int ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        hc,
   input  logic [9:0]        vc,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              wr_bank,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid
);

   localparam int                SHIFT = $clog2(SCALE);
   localparam logic [DATA_W-1:0] BG    = DATA_W'(BG_DATA);

   logic [DATA_W-1:0] mem0 [DEPTH];
   logic [DATA_W-1:0] mem1 [DEPTH];

   logic disp_bank_q, disp_bank_d;
   logic swap_pending_q, swap_pending_d;
   logic swap_ack_q, swap_ack_d;
   logic frame_end, do_swap, wr_ok;

   logic [9:0]         sx, sy;
   logic signed [31:0] sx_s, sy_s, x_s, y_s, addr_s;
   logic               in_win, active;

   logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;
   logic              vld_p1_q, vld_p1_d;
   logic              bank_p1_q, bank_p1_d;
   logic [DATA_W-1:0] ram_out;
   logic [DATA_W-1:0] pix_data_p2_q, pix_data_p2_d;
   logic              vld_p2_q, vld_p2_d;

   // Swap control: a request is latched until the next frame end, which is the only swap point
   always_comb begin
      frame_end      = (32'(hc) == H_TOTAL - 1) && (32'(vc) == V_TOTAL - 1);
      do_swap        = frame_end && (swap_pending_q || swap_req || (AUTO_SWAP != 0));
      disp_bank_d    = disp_bank_q ^ do_swap;
      swap_pending_d = do_swap ? 1'b0 : (swap_pending_q | swap_req);
      swap_ack_d     = do_swap;
      wr_ok          = wr_en && (32'(wr_addr) < DEPTH);
   end

   // Stage 0: screen coordinates to bank address; signed math keeps left-of-window values negative
   always_comb begin
      sx   = hc >> SHIFT;
      sy   = vc >> SHIFT;
      sx_s = signed'(32'(sx));
      sy_s = signed'(32'(sy));
      if (ROTATE != 0) begin
         x_s    = FB_COLS - 1 - sy_s;
         y_s    = sx_s - Y_OFFSET;
         in_win = (sx_s >= Y_OFFSET) && (sx_s < Y_OFFSET + FB_ROWS) && (sy_s < FB_COLS);
         addr_s = x_s * FB_ROWS + y_s;
      end else begin
         x_s    = sx_s;
         y_s    = sy_s - Y_OFFSET;
         in_win = (sx_s < FB_COLS) && (sy_s >= Y_OFFSET) && (sy_s < Y_OFFSET + FB_ROWS);
         addr_s = y_s * FB_COLS + x_s;
      end
      active    = (32'(hc) < H_ACTIVE) && (32'(vc) < V_ACTIVE);
      vld_p1_d  = active && in_win;
      addr_p1_d = vld_p1_d ? addr_s[ADDR_W-1:0] : '0;
      bank_p1_d = disp_bank_q;
   end

   // Stage 1 -> 2: registered address feeds the RAM read; bank was frozen with the address
   always_comb begin
      ram_out       = bank_p1_q ? mem1[addr_p1_q] : mem0[addr_p1_q];
      pix_data_p2_d = vld_p1_q ? ram_out : BG;
      vld_p2_d      = vld_p1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         disp_bank_q    <= 1'b0;
         swap_pending_q <= 1'b0;
         swap_ack_q     <= 1'b0;
         vld_p1_q       <= 1'b0;
         vld_p2_q       <= 1'b0;
         pix_data_p2_q  <= BG;
      end else begin
         disp_bank_q    <= disp_bank_d;
         swap_pending_q <= swap_pending_d;
         swap_ack_q     <= swap_ack_d;
         vld_p1_q       <= vld_p1_d;
         vld_p2_q       <= vld_p2_d;
         pix_data_p2_q  <= pix_data_p2_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_p1_q <= addr_p1_d;
      bank_p1_q <= bank_p1_d;
   end

   // Write bank is the one not on display; out-of-range addresses are dropped
   always_ff @(posedge clk) begin
      if (wr_ok && disp_bank_q) mem0[wr_addr] <= wr_data;
      if (wr_ok && !disp_bank_q) mem1[wr_addr] <= wr_data;
   end

   assign swap_ack  = swap_ack_q;
   assign wr_bank   = ~disp_bank_q;
   assign pix_data  = pix_data_p2_q;
   assign pix_valid = vld_p2_q;

endmodule

// File: tb/tb_vga_pingpong_fb.sv
// Directed bench for vga_pingpong_fb: swap handshake, readback latency, window edges, auto swap.
module tb_vga_pingpong_fb;

   localparam int DEPTH  = 63360;
   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst, rst_a;
   logic [9:0]        hc, vc;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              swap_req;
   logic              swap_ack, wr_bank, pix_valid;
   logic [7:0]        pix_data;
   logic              swap_ack_a, wr_bank_a, pix_valid_a;
   logic [7:0]        pix_data_a;

   int n_pass  = 0;
   int n_total = 0;
   logic [7:0] sb0 [int];
   logic [7:0] sb1 [int];
   logic       exp_wb;

   always #5 clk = ~clk;

   vga_pingpong_fb dut (
      .clk(clk), .rst(rst), .hc(hc), .vc(vc),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .swap_req(swap_req), .swap_ack(swap_ack), .wr_bank(wr_bank),
      .pix_data(pix_data), .pix_valid(pix_valid)
   );

   vga_pingpong_fb #(.AUTO_SWAP(1)) dut_a (
      .clk(clk), .rst(rst_a), .hc(hc), .vc(vc),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .swap_req(swap_req), .swap_ack(swap_ack_a), .wr_bank(wr_bank_a),
      .pix_data(pix_data_a), .pix_valid(pix_valid_a)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic frame_end_cycle;
      hc = 10'd799;
      vc = 10'd524;
      tick();
      hc = 10'd0;
      vc = 10'd0;
   endtask

   task automatic sample_px(input int h, input int v, output logic [7:0] d, output logic val);
      hc = 10'(h);
      vc = 10'(v);
      tick();
      tick();
      d   = pix_data;
      val = pix_valid;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = 16'(a);
      wr_data = d;
      tick();
      wr_en = 1'b0;
      if (a < DEPTH) begin
         if (exp_wb) sb1[a] = d;
         else sb0[a] = d;
      end
   endtask

   function automatic int hc_of(input int a);
      return 2 * ((a % 264) + 24);
   endfunction

   function automatic int vc_of(input int a);
      return 2 * (239 - a / 264);
   endfunction

   task automatic test_reset;
      rst = 1'b1; rst_a = 1'b1;
      hc = '0; vc = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
      tick(); tick(); tick();
      n_total++; if (wr_bank !== 1'b1) $display("FAIL reset_wr_bank: got %b want 1", wr_bank); else n_pass++;
      n_total++; if (swap_ack !== 1'b0) $display("FAIL reset_swap_ack: got %b want 0", swap_ack); else n_pass++;
      n_total++; if (pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %b want 0", pix_valid); else n_pass++;
      n_total++; if (pix_data !== 8'h00) $display("FAIL reset_pix_data: got %h want 00", pix_data); else n_pass++;
      rst = 1'b0;
      exp_wb = 1'b1;
      for (int f = 0; f < 2; f++) begin
         tick();
         frame_end_cycle();
         n_total++; if (swap_ack !== 1'b0) $display("FAIL idle_frame_ack: got %b want 0", swap_ack); else n_pass++;
         n_total++; if (wr_bank !== 1'b1) $display("FAIL idle_frame_wr_bank: got %b want 1", wr_bank); else n_pass++;
      end
   endtask

   task automatic test_write_readback;
      logic [7:0] d;
      logic       v;
      wr(0, 8'hA5);
      wr(263, 8'h3C);
      wr(63096, 8'h77);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      tick();
      n_total++; if (wr_bank !== 1'b1) $display("FAIL no_midframe_swap: got %b want 1", wr_bank); else n_pass++;
      frame_end_cycle();
      exp_wb = 1'b0;
      n_total++; if (swap_ack !== 1'b1) $display("FAIL swap_ack_pulse: got %b want 1", swap_ack); else n_pass++;
      n_total++; if (wr_bank !== 1'b0) $display("FAIL swap_wr_bank: got %b want 0", wr_bank); else n_pass++;
      tick();
      n_total++; if (swap_ack !== 1'b0) $display("FAIL swap_ack_single: got %b want 0", swap_ack); else n_pass++;
      sample_px(48, 478, d, v);
      n_total++; if (d !== 8'hA5) $display("FAIL readback_data: got %h want a5", d); else n_pass++;
      n_total++; if (v !== 1'b1) $display("FAIL readback_valid: got %b want 1", v); else n_pass++;
   endtask

   task automatic test_window_edges;
      int         eh [8];
      int         ev [8];
      logic [7:0] ed [8];
      logic       eval [8];
      logic [7:0] d;
      logic       v;
      eh   = '{46,    47,    575,   576,   640,   48,    48,    700};
      ev   = '{478,   478,   478,   478,   478,   0,     480,   478};
      ed   = '{8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00};
      eval = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
      for (int i = 0; i < 8; i++) begin
         sample_px(eh[i], ev[i], d, v);
         n_total++;
         if (d !== ed[i] || v !== eval[i])
            $display("FAIL window_hc%0d_vc%0d: got data=%h valid=%b want data=%h valid=%b",
                     eh[i], ev[i], d, v, ed[i], eval[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      hc = 10'd48; vc = 10'd478;
      tick();
      hc = 10'd575;
      tick();
      n_total++; if (pix_data !== 8'hA5 || pix_valid !== 1'b1)
         $display("FAIL b2b_0: got %h/%b want a5/1", pix_data, pix_valid); else n_pass++;
      hc = 10'd576;
      tick();
      n_total++; if (pix_data !== 8'h3C || pix_valid !== 1'b1)
         $display("FAIL b2b_1: got %h/%b want 3c/1", pix_data, pix_valid); else n_pass++;
      hc = 10'd0;
      tick();
      n_total++; if (pix_data !== 8'h00 || pix_valid !== 1'b0)
         $display("FAIL b2b_2: got %h/%b want 00/0", pix_data, pix_valid); else n_pass++;
   endtask

   task automatic test_swap_same_cycle;
      hc = 10'd799; vc = 10'd524; swap_req = 1'b1;
      tick();
      hc = 10'd0; vc = 10'd0; swap_req = 1'b0;
      exp_wb = 1'b1;
      n_total++; if (swap_ack !== 1'b1) $display("FAIL same_cycle_ack: got %b want 1", swap_ack); else n_pass++;
      n_total++; if (wr_bank !== 1'b1) $display("FAIL same_cycle_wr_bank: got %b want 1", wr_bank); else n_pass++;
      tick();
      frame_end_cycle();
      n_total++; if (swap_ack !== 1'b0) $display("FAIL no_carry_ack: got %b want 0", swap_ack); else n_pass++;
      n_total++; if (wr_bank !== 1'b1) $display("FAIL no_carry_wr_bank: got %b want 1", wr_bank); else n_pass++;
   endtask

   task automatic test_write_at_swap;
      logic [7:0] d;
      logic       v;
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      hc = 10'd799; vc = 10'd524;
      wr_en = 1'b1; wr_addr = 16'd5; wr_data = 8'h11;
      tick();
      sb1[5] = 8'h11;
      n_total++; if (swap_ack !== 1'b1) $display("FAIL wr_swap_ack: got %b want 1", swap_ack); else n_pass++;
      hc = 10'd0; vc = 10'd0; wr_data = 8'h22;
      tick();
      wr_en = 1'b0;
      sb0[5] = 8'h22;
      exp_wb = 1'b0;
      n_total++; if (wr_bank !== 1'b0) $display("FAIL wr_swap_bank: got %b want 0", wr_bank); else n_pass++;
      sample_px(hc_of(5), vc_of(5), d, v);
      n_total++; if (d !== 8'h11 || v !== 1'b1) $display("FAIL write_old_bank: got %h/%b want 11/1", d, v); else n_pass++;
      hc = 10'd799; vc = 10'd524; swap_req = 1'b1;
      tick();
      hc = 10'd0; vc = 10'd0; swap_req = 1'b0;
      exp_wb = 1'b1;
      sample_px(hc_of(5), vc_of(5), d, v);
      n_total++; if (d !== 8'h22 || v !== 1'b1) $display("FAIL write_new_bank: got %h/%b want 22/1", d, v); else n_pass++;
   endtask

   task automatic test_bad_addr;
      logic [7:0] d;
      logic       v;
      wr(DEPTH, 8'hEE);
      wr(63359, 8'h5A);
      hc = 10'd799; vc = 10'd524; swap_req = 1'b1;
      tick();
      hc = 10'd0; vc = 10'd0; swap_req = 1'b0;
      exp_wb = 1'b0;
      foreach (sb1[a]) begin
         sample_px(hc_of(a), vc_of(a), d, v);
         n_total++;
         if (d !== sb1[a] || v !== 1'b1)
            $display("FAIL bank1_addr%0d: got %h/%b want %h/1", a, d, v, sb1[a]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame;
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_wb = 1'b1;
      n_total++; if (wr_bank !== 1'b1 || swap_ack !== 1'b0 || pix_valid !== 1'b0)
         $display("FAIL midreset_state: got bank=%b ack=%b valid=%b want 1/0/0", wr_bank, swap_ack, pix_valid);
      else n_pass++;
      tick();
      frame_end_cycle();
      n_total++; if (swap_ack !== 1'b0) $display("FAIL midreset_no_swap_ack: got %b want 0", swap_ack); else n_pass++;
      n_total++; if (wr_bank !== 1'b1) $display("FAIL midreset_no_swap_bank: got %b want 1", wr_bank); else n_pass++;
   endtask

   task automatic test_auto_swap;
      logic eb;
      rst_a = 1'b0;
      tick();
      n_total++; if (wr_bank_a !== 1'b1) $display("FAIL auto_start_bank: got %b want 1", wr_bank_a); else n_pass++;
      eb = 1'b1;
      for (int f = 0; f < 3; f++) begin
         frame_end_cycle();
         eb = ~eb;
         n_total++; if (swap_ack_a !== 1'b1 || wr_bank_a !== eb)
            $display("FAIL auto_frame%0d: got ack=%b bank=%b want 1/%b", f, swap_ack_a, wr_bank_a, eb);
         else n_pass++;
         tick();
         n_total++; if (swap_ack_a !== 1'b0) $display("FAIL auto_ack_single%0d: got %b want 0", f, swap_ack_a); else n_pass++;
      end
      n_total++; if (wr_bank !== exp_wb) $display("FAIL manual_unaffected: got %b want %b", wr_bank, exp_wb); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_readback();
      test_window_edges();
      test_back_to_back();
      test_swap_same_cycle();
      test_write_at_swap();
      test_bad_addr();
      test_reset_mid_frame();
      test_auto_swap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
